// File: rtl/sv_pkg.sv
// -----------------------------------------------------------------------------
// sv_pkg
// Shared definitions for the bus arbiter slice: the owner/state encoding that
// is also presented on the arbiter's owner port, and the default ownership
// limits for DMA bursts and LCD holds.
// -----------------------------------------------------------------------------
package sv_pkg;

    // The encoding is visible on the owner port, so the values are fixed.
    typedef enum logic [1:0] {
        OWN_CPU  = 2'd0,
        OWN_DMA  = 2'd1,
        OWN_LCD  = 2'd2,
        OWN_TURN = 2'd3
    } owner_e;

    localparam int DMA_BURST_MAX_DEF = 16;
    localparam int LCD_HOLD_MAX_DEF  = 8;

endpackage : sv_pkg

// File: rtl/sv_sat_counter.sv
// -----------------------------------------------------------------------------
// sv_sat_counter
// Up counter with synchronous clear that sticks at all-ones instead of
// wrapping.
//   clk      in            clock
//   reset_n  in            asynchronous active-low reset, clears the count
//   clr      in            synchronous clear, has priority over inc
//   inc      in            count enable
//   cnt      out [WIDTH]   current count
// -----------------------------------------------------------------------------
module sv_sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] cnt
);

    logic [WIDTH-1:0] cnt_q;

    // NOTE: clocked state uses non-blocking (<=) assignments so every flop
    // samples the pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_q <= cnt_q + WIDTH'(1);
        end
    end

    assign cnt = cnt_q;

endmodule : sv_sat_counter

// File: rtl/sv_bus_arbiter.sv
// -----------------------------------------------------------------------------
// sv_bus_arbiter
// Shares one memory bus between the CPU (default owner, no request line), a
// DMA engine and an LCD fetch unit. Priority is LCD > DMA > CPU. Every change
// of owner passes through a single dead TURN cycle. DMA bursts and LCD holds
// are capped; when a cap is hit the bus returns to the CPU for one cycle.
//   clk            in       system clock
//   reset_n        in       asynchronous active-low reset
//   lcd_req        in       LCD requests the bus
//   lcd_gnt        out      LCD owns the bus (registered)
//   dma_req        in       DMA requests the bus
//   dma_gnt        out      DMA owns the bus (registered)
//   cpu_rdy        out      CPU owns the bus, drives CPU RDY (registered)
//   cpu_addr/dout/we in     CPU bus request
//   dma_addr/dout/we in     DMA bus request (14-bit address, zero-extended)
//   bus_addr/dout/we out    shared bus, muxed from the registered owner
//   owner          out [2]  0=CPU 1=DMA 2=LCD 3=TURN
//   cpu_stall_cnt  out [16] saturating count of cycles with cpu_rdy=0
// -----------------------------------------------------------------------------
module sv_bus_arbiter
    import sv_pkg::*;
#(
    parameter int DMA_BURST_MAX = DMA_BURST_MAX_DEF,
    parameter int LCD_HOLD_MAX  = LCD_HOLD_MAX_DEF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        lcd_req,
    output logic        lcd_gnt,
    input  logic        dma_req,
    output logic        dma_gnt,
    output logic        cpu_rdy,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_dout,
    input  logic        cpu_we,
    input  logic [13:0] dma_addr,
    input  logic [7:0]  dma_dout,
    input  logic        dma_we,
    output logic [15:0] bus_addr,
    output logic [7:0]  bus_dout,
    output logic        bus_we,
    output logic [1:0]  owner,
    output logic [15:0] cpu_stall_cnt
);

    localparam int BURST_W = $clog2(DMA_BURST_MAX) + 1;
    localparam int HOLD_W  = $clog2(LCD_HOLD_MAX) + 1;
    // Counters hold the number of cycles already owned before the current
    // one, so MAX-1 means the current cycle is the last one allowed.
    localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(DMA_BURST_MAX - 1);
    localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(LCD_HOLD_MAX - 1);

    owner_e state_q, state_d;
    owner_e target_q, target_d;   // owner to hand over to after TURN
    logic   lcd_gnt_q, dma_gnt_q, cpu_rdy_q;

    logic [BURST_W-1:0] burst_cnt;
    logic [HOLD_W-1:0]  hold_cnt;
    logic               burst_last, hold_last;

    assign burst_last = (burst_cnt == BURST_LAST);
    assign hold_last  = (hold_cnt == HOLD_LAST);

    // NOTE: every variable written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        unique case (state_q)
            OWN_CPU: begin
                // One CPU cycle is always granted before re-arbitrating,
                // which also provides the forced CPU slot after a cap.
                if (lcd_req) begin
                    state_d  = OWN_TURN;
                    target_d = OWN_LCD;
                end else if (dma_req) begin
                    state_d  = OWN_TURN;
                    target_d = OWN_DMA;
                end
            end
            OWN_DMA: begin
                if (lcd_req) begin
                    state_d  = OWN_TURN;
                    target_d = OWN_LCD;
                end else if (!dma_req || burst_last) begin
                    state_d  = OWN_TURN;
                    target_d = OWN_CPU;
                end
            end
            OWN_LCD: begin
                if (!lcd_req || hold_last) begin
                    state_d  = OWN_TURN;
                    target_d = OWN_CPU;
                end
            end
            OWN_TURN: begin
                // Target was latched on entry; a dropped request does not
                // cancel the handover.
                state_d = target_q;
            end
            default: state_d = OWN_CPU;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= OWN_CPU;
            target_q  <= OWN_CPU;
            lcd_gnt_q <= 1'b0;
            dma_gnt_q <= 1'b0;
            cpu_rdy_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            target_q  <= target_d;
            lcd_gnt_q <= (state_d == OWN_LCD);
            dma_gnt_q <= (state_d == OWN_DMA);
            cpu_rdy_q <= (state_d == OWN_CPU);
        end
    end

    // Burst/hold counters clear on the TURN cycle that enters their state
    // and count each owned cycle afterwards.
    sv_sat_counter #(.WIDTH(BURST_W)) u_burst_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     ((state_d == OWN_DMA) && (state_q != OWN_DMA)),
        .inc     (state_q == OWN_DMA),
        .cnt     (burst_cnt)
    );

    sv_sat_counter #(.WIDTH(HOLD_W)) u_hold_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     ((state_d == OWN_LCD) && (state_q != OWN_LCD)),
        .inc     (state_q == OWN_LCD),
        .cnt     (hold_cnt)
    );

    sv_sat_counter #(.WIDTH(16)) u_stall_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (1'b0),
        .inc     (!cpu_rdy_q),
        .cnt     (cpu_stall_cnt)
    );

    // Bus mux keys off the registered owner only, so requests never reach
    // the bus combinationally.
    always_comb begin
        bus_addr = cpu_addr;
        bus_dout = 8'h00;
        bus_we   = 1'b0;
        unique case (state_q)
            OWN_CPU: begin
                bus_dout = cpu_dout;
                bus_we   = cpu_we;
            end
            OWN_DMA: begin
                bus_addr = {2'b00, dma_addr};
                bus_dout = dma_dout;
                bus_we   = dma_we;
            end
            default: ;
        endcase
    end

    assign lcd_gnt = lcd_gnt_q;
    assign dma_gnt = dma_gnt_q;
    assign cpu_rdy = cpu_rdy_q;
    assign owner   = state_q;

endmodule : sv_bus_arbiter

// File: tb/tb_sv_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sv_bus_arbiter
// Randomised and directed stimulus for sv_bus_arbiter. A run-length model of
// bus ownership predicts each cycle's outputs into a queue; a monitor pops
// and compares one entry after every rising edge.
// -----------------------------------------------------------------------------
module tb_sv_bus_arbiter;
    import sv_pkg::*;

    localparam int DMAX = DMA_BURST_MAX_DEF;
    localparam int LMAX = LCD_HOLD_MAX_DEF;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        lcd_req, dma_req;
    logic        lcd_gnt, dma_gnt, cpu_rdy;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_dout;
    logic        cpu_we;
    logic [13:0] dma_addr;
    logic [7:0]  dma_dout;
    logic        dma_we;
    logic [15:0] bus_addr;
    logic [7:0]  bus_dout;
    logic        bus_we;
    logic [1:0]  owner;
    logic [15:0] cpu_stall_cnt;

    sv_bus_arbiter dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .lcd_req       (lcd_req),
        .lcd_gnt       (lcd_gnt),
        .dma_req       (dma_req),
        .dma_gnt       (dma_gnt),
        .cpu_rdy       (cpu_rdy),
        .cpu_addr      (cpu_addr),
        .cpu_dout      (cpu_dout),
        .cpu_we        (cpu_we),
        .dma_addr      (dma_addr),
        .dma_dout      (dma_dout),
        .dma_we        (dma_we),
        .bus_addr      (bus_addr),
        .bus_dout      (bus_dout),
        .bus_we        (bus_we),
        .owner         (owner),
        .cpu_stall_cnt (cpu_stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  owner;
        logic        lcd_gnt;
        logic        dma_gnt;
        logic        cpu_rdy;
        logic [15:0] stall;
        logic [15:0] addr;
        logic [7:0]  dout;
        logic        we;
    } exp_t;

    exp_t sb[$];
    int   total_cnt = 0;
    int   pass_cnt  = 0;
    bit   fix_dma_addr = 1'b0;

    // Reference: who owns the bus, who is next after a TURN, how many
    // consecutive cycles the current owner has held it, and the stall total.
    int m_owner, m_target, m_run, m_stall;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic void model_reset();
        m_owner  = 0;
        m_target = 0;
        m_run    = 1;
        m_stall  = 0;
    endfunction

    // Drive one cycle of inputs at the falling edge and predict what the
    // DUT shows after the following rising edge.
    task automatic cycle(input logic lcd, input logic dma);
        int   nxt;
        exp_t e;
        @(negedge clk);
        lcd_req  = lcd;
        dma_req  = dma;
        cpu_addr = 16'($urandom);
        cpu_dout = 8'($urandom);
        cpu_we   = 1'($urandom);
        dma_addr = fix_dma_addr ? 14'h0ABC : 14'($urandom);
        dma_dout = 8'($urandom);
        dma_we   = 1'($urandom);

        nxt = m_owner;
        if (m_owner == 3) begin
            nxt = m_target;
        end else if (m_owner == 0) begin
            if (lcd)      begin nxt = 3; m_target = 2; end
            else if (dma) begin nxt = 3; m_target = 1; end
        end else if (m_owner == 1) begin
            if (lcd)                       begin nxt = 3; m_target = 2; end
            else if (!dma || m_run >= DMAX) begin nxt = 3; m_target = 0; end
        end else begin
            if (!lcd || m_run >= LMAX) begin nxt = 3; m_target = 0; end
        end

        if (m_owner != 0 && m_stall < 65535) m_stall++;
        m_run   = (nxt == m_owner) ? m_run + 1 : 1;
        m_owner = nxt;

        e.owner   = 2'(m_owner);
        e.lcd_gnt = (m_owner == 2);
        e.dma_gnt = (m_owner == 1);
        e.cpu_rdy = (m_owner == 0);
        e.stall   = 16'(m_stall);
        if (m_owner == 0) begin
            e.addr = cpu_addr; e.dout = cpu_dout; e.we = cpu_we;
        end else if (m_owner == 1) begin
            e.addr = {2'b00, dma_addr}; e.dout = dma_dout; e.we = dma_we;
        end else begin
            e.addr = cpu_addr; e.dout = 8'h00; e.we = 1'b0;
        end
        sb.push_back(e);
    endtask

    // Monitor: the DUT presents a new owner/bus state after every rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("owner",    32'(owner),         32'(e.owner));
                check("lcd_gnt",  32'(lcd_gnt),       32'(e.lcd_gnt));
                check("dma_gnt",  32'(dma_gnt),       32'(e.dma_gnt));
                check("cpu_rdy",  32'(cpu_rdy),       32'(e.cpu_rdy));
                check("stall",    32'(cpu_stall_cnt), 32'(e.stall));
                check("bus_addr", 32'(bus_addr),      32'(e.addr));
                check("bus_dout", 32'(bus_dout),      32'(e.dout));
                check("bus_we",   32'(bus_we),        32'(e.we));
            end
        end
    end

    task automatic idle_inputs();
        lcd_req  = 1'b0;
        dma_req  = 1'b0;
        cpu_addr = '0;
        cpu_dout = '0;
        cpu_we   = 1'b0;
        dma_addr = '0;
        dma_dout = '0;
        dma_we   = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_owner"},   32'(owner),         32'd0);
        check({tag, "_cpu_rdy"}, 32'(cpu_rdy),       32'd1);
        check({tag, "_lcd_gnt"}, 32'(lcd_gnt),       32'd0);
        check({tag, "_dma_gnt"}, 32'(dma_gnt),       32'd0);
        check({tag, "_stall"},   32'(cpu_stall_cnt), 32'd0);
    endtask

    initial begin
        logic lcd_r, dma_r;
        reset_n = 1'b0;
        idle_inputs();
        model_reset();
        repeat (3) @(negedge clk);
        #1 check_reset_state("reset");
        @(negedge clk);
        reset_n = 1'b1;

        // Idle: CPU keeps the bus, no stalls.
        repeat (100) cycle(1'b0, 1'b0);

        // Long DMA request: capped bursts separated by single CPU slots.
        fix_dma_addr = 1'b1;
        repeat (40) cycle(1'b0, 1'b1);
        fix_dma_addr = 1'b0;
        repeat (4) cycle(1'b0, 1'b0);

        // Simultaneous requests: LCD first, DMA after a CPU slot.
        repeat (6)  cycle(1'b1, 1'b1);
        repeat (25) cycle(1'b0, 1'b1);
        repeat (4)  cycle(1'b0, 1'b0);

        // LCD preempts DMA during its fifth owned cycle.
        repeat (6) cycle(1'b0, 1'b1);
        repeat (4) cycle(1'b1, 1'b1);
        repeat (4) cycle(1'b0, 1'b0);

        // Randomised requests with some persistence.
        lcd_r = 1'b0;
        dma_r = 1'b0;
        repeat (3000) begin
            if ($urandom_range(0, 7) == 0) lcd_r = !lcd_r;
            if ($urandom_range(0, 5) == 0) dma_r = !dma_r;
            cycle(lcd_r, dma_r);
        end
        repeat (4) cycle(1'b0, 1'b0);

        // Asynchronous reset in the middle of an LCD hold.
        repeat (4) cycle(1'b1, 1'b0);
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        idle_inputs();
        sb.delete();
        #1 check_reset_state("async_reset");
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        repeat (20) cycle(1'($urandom), 1'($urandom));

        // Permanent contention drives the stall counter into saturation.
        repeat (75000) cycle(1'b1, 1'b1);
        @(posedge clk);
        #2;
        check("stall_saturated", 32'(cpu_stall_cnt), 32'h0000_FFFF);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule : tb_sv_bus_arbiter
